// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte width, transmit-sequencer state type and counter width helpers
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to hold the value maxval.
  function automatic int cnt_w(input int maxval);
    return (maxval > 0) ? $clog2(maxval + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder: first set bit of valid after last_idx, wrapping
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] last_idx,
  output logic         any,
  output logic [W-1:0] idx
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest valid index is written last.
  always_comb begin
    any  = |valid;
    idx  = '0;
    cand = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last_idx) + k) % N;
      if (valid[cand]) begin
        idx = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter sequencing one UART transmitter among NREQ byte sources
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 15,
  localparam int GW         = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [GW-1:0]          grant_id,
  output logic                   active,
  output logic                   ack_err
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int AW = cnt_w(ACK_TIMEOUT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_SAT   = AW'(ACK_TIMEOUT);
  localparam logic [GW-1:0] LAST_IDX  = GW'(NREQ - 1);

  arb_state_t state, state_d;

  logic [GW-1:0]     rr_last;
  logic [GW-1:0]     pick_idx;
  logic              pick_any;
  logic [BW-1:0]     burst_cnt;
  logic [BW-1:0]     burst_inc;
  logic [AW-1:0]     ack_cnt;
  logic              end_flag;
  logic              sel_valid;
  logic              sel_last;
  logic [BYTE_W-1:0] sel_data;
  logic              take;
  logic              release_g;
  logic              timeout;
  logic              done;

  rr_pick #(
    .N (NREQ),
    .W (GW)
  ) u_pick (
    .valid    (req_valid),
    .last_idx (rr_last),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // View of the granted source only; other sources are invisible until rotation.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == SEND) && (grant_id == GW'(i)) && req_valid[i] && !tx_busy;
    end
  end

  assign burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
  assign active    = (state != IDLE);

  always_comb begin
    state_d   = state;
    take      = 1'b0;
    release_g = 1'b0;
    timeout   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!sel_valid) begin
          release_g = 1'b1;
          state_d   = IDLE;
        end else if (!tx_busy) begin
          take    = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt >= ACK_LAST) begin
          // Transmitter never acknowledged: count the byte as sent and move on.
          timeout = 1'b1;
          done    = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = end_flag ? IDLE : SEND;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data   <= '0;
      tx_start  <= 1'b0;
      grant_id  <= '0;
      ack_err   <= 1'b0;
      burst_cnt <= '0;
      ack_cnt   <= '0;
      end_flag  <= 1'b0;
      rr_last   <= LAST_IDX;
    end else begin
      tx_start <= take;
      ack_err  <= timeout;
      if (state == IDLE && pick_any) begin
        grant_id  <= pick_idx;
        burst_cnt <= '0;
      end
      if (take) begin
        tx_data   <= sel_data;
        burst_cnt <= burst_inc;
        end_flag  <= sel_last | (burst_inc == BURST_MAX);
        ack_cnt   <= '0;
      end else if (state == WAIT_ACK && ack_cnt != ACK_SAT) begin
        ack_cnt <= ack_cnt + 1'b1;
      end
      if (release_g || (done && end_flag)) begin
        rr_last <= grant_id;
      end
    end
  end

endmodule
